// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle FETCH/WAIT/DECODE/EXECUTE/WRITEBACK control sequencer
// Drives PC, instruction-memory and register-bank strobes; free-run or single-step, with halt detect.
module cpu_sequencer #(
   parameter int unsigned MEM_WAIT    = 1,
   parameter int unsigned COUNT_W     = 16,
   parameter logic [6:0]  HALT_OPCODE = 7'h00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   input  logic               step,
   input  logic [6:0]         opcode,
   input  logic               regwrite_dec,
   output logic               pc_en,
   output logic               mem_read,
   output logic               ir_load,
   output logic               reg_write,
   output logic               busy,
   output logic               halted,
   output logic [2:0]         state,
   output logic [COUNT_W-1:0] instr_count
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_FETCH     = 3'd1,
      S_WAIT      = 3'd2,
      S_DECODE    = 3'd3,
      S_EXECUTE   = 3'd4,
      S_WRITEBACK = 3'd5,
      S_HALT      = 3'd6,
      S_BAD       = 3'd7
   } state_t;

   localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

   state_t     cur;
   state_t     nxt;
   logic       step_q;
   logic       step_rise;
   logic [3:0] wait_cnt;

   // step_q resets high so a step held through reset release is not an edge
   assign step_rise = step & ~step_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cur         <= S_IDLE;
         step_q      <= 1'b1;
         wait_cnt    <= '0;
         instr_count <= '0;
      end else begin
         cur    <= nxt;
         step_q <= step;
         if (cur == S_FETCH)
            wait_cnt <= WAIT_INIT;
         else if (cur == S_WAIT && wait_cnt != 4'd0)
            wait_cnt <= wait_cnt - 4'd1;
         if (cur == S_WRITEBACK)
            instr_count <= instr_count + COUNT_W'(1);
      end
   end

   always_comb begin
      nxt      = cur;
      pc_en    = 1'b0;
      mem_read = 1'b0;
      ir_load  = 1'b0;
      busy     = 1'b1;
      halted   = 1'b0;
      case (cur)
         S_IDLE: begin
            busy = 1'b0;
            if (run || step_rise)
               nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (MEM_WAIT == 0) begin
               ir_load = 1'b1;
               nxt     = S_DECODE;
            end else begin
               nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            mem_read = 1'b1;
            // <=1 rather than ==1 so a corrupted zero count cannot stall here
            if (wait_cnt <= 4'd1) begin
               ir_load = 1'b1;
               nxt     = S_DECODE;
            end
         end
         S_DECODE:    nxt = (opcode == HALT_OPCODE) ? S_HALT : S_EXECUTE;
         S_EXECUTE:   nxt = S_WRITEBACK;
         S_WRITEBACK: begin
            pc_en = 1'b1;
            nxt   = run ? S_FETCH : S_IDLE;
         end
         S_HALT: begin
            busy   = 1'b0;
            halted = 1'b1;
         end
         default:     nxt = S_IDLE;
      endcase
   end

   assign reg_write = (cur == S_WRITEBACK) & regwrite_dec;
   assign state     = cur;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer
// Stimulus pushes expected retirements; a monitor pops one per pc_en pulse.
module tb_cpu_sequencer;

   logic        clk;
   logic        reset;
   logic        run;
   logic        step;
   logic [6:0]  opcode;
   logic        regwrite_dec;
   logic        pc_en;
   logic        mem_read;
   logic        ir_load;
   logic        reg_write;
   logic        busy;
   logic        halted;
   logic [2:0]  state;
   logic [15:0] instr_count;

   cpu_sequencer #(.MEM_WAIT(1), .COUNT_W(16), .HALT_OPCODE(7'h00)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
      .regwrite_dec(regwrite_dec), .pc_en(pc_en), .mem_read(mem_read),
      .ir_load(ir_load), .reg_write(reg_write), .busy(busy), .halted(halted),
      .state(state), .instr_count(instr_count)
   );

   typedef struct {
      logic        rw;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   int   pc_times[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   pc_cnt  = 0;
   int   rw_cnt  = 0;
   int   ir_cnt  = 0;
   int   mr_cnt  = 0;
   int   mcyc    = 0;
   int   ir_state = -1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic push(input logic rw, input logic [15:0] cnt);
      exp_t e;
      e.rw  = rw;
      e.cnt = cnt;
      sb.push_back(e);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // monitor: one scoreboard entry per retired instruction
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         mcyc++;
         if (pc_en) begin
            pc_cnt++;
            pc_times.push_back(mcyc);
            if (sb.size() == 0) begin
               chk("sb_unexpected_pc_en", 32'(1), 32'(0));
            end else begin
               e = sb.pop_front();
               chk("sb_reg_write", 32'(reg_write), 32'(e.rw));
               chk("sb_count_at_wb", 32'(instr_count), 32'(e.cnt));
            end
         end
         if (reg_write) rw_cnt++;
         if (mem_read)  mr_cnt++;
         if (ir_load) begin
            ir_cnt++;
            ir_state = int'(state);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   int pc0, rw0, ir0, mr0;
   int seq[7] = '{0, 1, 2, 3, 4, 5, 0};

   initial begin
      reset = 1'b0; run = 1'b0; step = 1'b1; opcode = 7'h13; regwrite_dec = 1'b0;

      // reset state, then release with step held high
      repeat (2) @(negedge clk);
      chk("rst_state", 32'(state), 32'(0));
      chk("rst_pc_en", 32'(pc_en), 32'(0));
      chk("rst_mem_read", 32'(mem_read), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_halted", 32'(halted), 32'(0));
      chk("rst_count", 32'(instr_count), 32'(0));
      reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("held_step_idle", 32'(state), 32'(0));
      end
      chk("held_step_no_pc_en", 32'(pc_cnt), 32'(0));
      chk("held_step_count", 32'(instr_count), 32'(0));

      // single step, opcode 0x33 with register write
      step = 1'b0;
      @(negedge clk);
      opcode = 7'h33; regwrite_dec = 1'b1;
      push(1'b1, 16'd0);
      pc0 = pc_cnt; rw0 = rw_cnt; ir0 = ir_cnt; mr0 = mr_cnt;
      step = 1'b1;
      chk("step_seq0", 32'(state), 32'(seq[0]));
      for (int i = 1; i < 7; i++) begin
         @(negedge clk);
         chk("step_seq", 32'(state), 32'(seq[i]));
      end
      chk("step_mem_read_cycles", 32'(mr_cnt - mr0), 32'(2));
      chk("step_ir_load_cycles", 32'(ir_cnt - ir0), 32'(1));
      chk("step_ir_load_state", 32'(ir_state), 32'(2));
      chk("step_pc_en_cycles", 32'(pc_cnt - pc0), 32'(1));
      chk("step_reg_write_cycles", 32'(rw_cnt - rw0), 32'(1));
      chk("step_count", 32'(instr_count), 32'(1));

      // free-run three instructions, no register write
      do_reset();
      opcode = 7'h13; regwrite_dec = 1'b0;
      push(1'b0, 16'd0); push(1'b0, 16'd1); push(1'b0, 16'd2);
      pc_times.delete();
      pc0 = pc_cnt; rw0 = rw_cnt;
      run = 1'b1;
      repeat (15) @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      chk("run3_count", 32'(instr_count), 32'(3));
      chk("run3_idle", 32'(state), 32'(0));
      chk("run3_pc_en", 32'(pc_cnt - pc0), 32'(3));
      chk("run3_no_reg_write", 32'(rw_cnt - rw0), 32'(0));
      chk("run3_pc_times", 32'(pc_times.size()), 32'(3));
      if (pc_times.size() == 3) begin
         chk("run3_interval1", 32'(pc_times[1] - pc_times[0]), 32'(5));
         chk("run3_interval2", 32'(pc_times[2] - pc_times[1]), 32'(5));
      end

      // halt on the third instruction's decode
      do_reset();
      opcode = 7'h13; regwrite_dec = 1'b0;
      push(1'b0, 16'd0); push(1'b0, 16'd1);
      pc0 = pc_cnt;
      run = 1'b1;
      repeat (11) @(negedge clk);
      opcode = 7'h00;
      repeat (3) @(negedge clk);
      chk("halt_state", 32'(state), 32'(6));
      chk("halt_halted", 32'(halted), 32'(1));
      chk("halt_busy", 32'(busy), 32'(0));
      chk("halt_count", 32'(instr_count), 32'(2));
      chk("halt_pc_en", 32'(pc_cnt - pc0), 32'(2));
      for (int i = 0; i < 5; i++) begin
         step = 1'b0;
         @(negedge clk);
         step = 1'b1;
         @(negedge clk);
      end
      chk("halt_sticky_state", 32'(state), 32'(6));
      chk("halt_sticky_count", 32'(instr_count), 32'(2));
      chk("halt_sticky_pc_en", 32'(pc_cnt - pc0), 32'(2));
      reset = 1'b0;
      #1;
      chk("halt_reset_state", 32'(state), 32'(0));
      chk("halt_reset_count", 32'(instr_count), 32'(0));
      chk("halt_reset_halted", 32'(halted), 32'(0));
      @(negedge clk);
      run = 1'b0; opcode = 7'h13;
      @(negedge clk);
      reset = 1'b1;

      // asynchronous reset in the middle of WAIT
      regwrite_dec = 1'b1;
      step = 1'b0;
      @(negedge clk);
      pc0 = pc_cnt;
      step = 1'b1;
      repeat (2) @(negedge clk);
      chk("abort_in_wait", 32'(state), 32'(2));
      reset = 1'b0;
      #1;
      chk("abort_state", 32'(state), 32'(0));
      chk("abort_count", 32'(instr_count), 32'(0));
      chk("abort_mem_read", 32'(mem_read), 32'(0));
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("abort_no_pc_en", 32'(pc_cnt - pc0), 32'(0));

      // second step edge during EXECUTE is dropped
      step = 1'b0;
      @(negedge clk);
      opcode = 7'h33; regwrite_dec = 1'b1;
      push(1'b1, 16'd0);
      pc0 = pc_cnt;
      step = 1'b1;
      repeat (2) @(negedge clk);
      step = 1'b0;
      repeat (2) @(negedge clk);
      chk("drop_in_execute", 32'(state), 32'(4));
      step = 1'b1;
      repeat (8) @(negedge clk);
      chk("drop_idle", 32'(state), 32'(0));
      chk("drop_count", 32'(instr_count), 32'(1));
      chk("drop_pc_en", 32'(pc_cnt - pc0), 32'(1));
      chk("drop_busy", 32'(busy), 32'(0));

      @(negedge clk);
      #2;
      chk("sb_drained", 32'(sb.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
